fifo_uart_tx: RTL
=================

Name: fifo_uart_tx

Overview:
- Drain engine on the read side of the 32-bit synchronous FIFO.
- Whenever the FIFO is non-empty and the block is enabled, it pops one word with a single-cycle read-enable pulse and captures it.
- It then transmits the word as four 8N1 UART frames, least-significant byte first.
- It is the consumer counterpart to the FIFO's write-side producer and provides the serial egress path of the design.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit period; legal range ≥2.
- DATA_W, 32, FIFO word width; fixed at 32, giving 4 bytes per word.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  drain enable; sampled only in IDLE.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  32  FIFO data_out; valid on the cycle after fifo_rd_en is high.
- fifo_rd_en  output  1  FIFO read enable; one-cycle pulse per word.
- tx  output  1  UART serial line; idles high.
- busy  output  1  high in every state except IDLE.
- word_done  output  1  one-cycle pulse when the stop bit of byte 3 completes.

Behaviour:
- Reset values (asynchronous):
  - state=IDLE, tx=1, fifo_rd_en=0, busy=0, word_done=0.
  - Shift register, byte index and baud/bit counters are all 0.
- States: IDLE, POP, LOAD, START, DATA, STOP.
- IDLE:
  - tx=1.
  - If en=1 and fifo_empty=0, go to POP.
- POP:
  - fifo_rd_en=1 for exactly this one cycle; go to LOAD.
- LOAD:
  - Capture fifo_data into the 32-bit word register; byte_idx=0; go to START.
  - fifo_empty is not re-checked here.
- START:
  - tx=0 for CLKS_PER_BIT cycles; load byte word[8*byte_idx+7 : 8*byte_idx] into the 8-bit shifter; go to DATA.
- DATA:
  - 8 bit periods, LSB first, each exactly CLKS_PER_BIT cycles; bit counter 0..7.
  - After bit 7, go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - At the end, if byte_idx<3: byte_idx+=1, go to START.
  - Else pulse word_done for one cycle, go to IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and resets on every state change into START/DATA/STOP.
  - Width is $clog2(CLKS_PER_BIT).
- Timing:
  - One word occupies 1 (POP) + 1 (LOAD) + 40·CLKS_PER_BIT cycles from leaving IDLE to re-entering IDLE.
  - IDLE lasts at least 1 cycle between words, so back-to-back words are separated by ≥1 idle-high cycle plus the POP and LOAD cycles (tx stays high during all three).
- Output registration:
  - tx is registered; no combinational path from inputs to tx.
  - fifo_rd_en is a registered decode of state==POP.
- en deasserted mid-word: the current word completes all 4 bytes, and no new pop occurs.
- fifo_empty toggling during transmission is ignored; it is sampled only in IDLE.
- Never pop when fifo_empty=1, so no underflow reads occur.
- Reset mid-frame:
  - tx returns high immediately and the in-flight word is lost.
  - No fifo_rd_en is generated until the block is back in IDLE with a non-empty FIFO.

Test Plan (CLKS_PER_BIT=4 unless noted):
- Reset/idle:
  - Stimulus: rst=1 then 0, fifo_empty=1, en=1.
  - Required: tx=1, busy=0, fifo_rd_en never asserted for 100 cycles.
- Single word:
  - Stimulus: FIFO holds 0x12345678.
  - Required: exactly one fifo_rd_en pulse; tx frames carry bytes 0x78, 0x56, 0x34, 0x12, each start=0, LSB first, stop=1, 4 cycles per bit; word_done pulses once, 160 cycles after LOAD; busy then drops.
- Back-to-back words:
  - Stimulus: 4 random words pre-written to the FIFO.
  - Required: exactly 4 rd_en pulses, 16 frames decoded by the bench UART model matching the written words in order, 4 word_done pulses, tx high between words.
- Enable gating:
  - Stimulus: en=0 with the FIFO non-empty.
  - Required: no pop.
  - Stimulus: drop en during byte 1 of word 0xA5A5_00FF.
  - Required: all 4 bytes (0xFF, 0x00, 0xA5, 0xA5) are sent, then no further pop.
- Reset mid-operation:
  - Stimulus: assert rst during DATA bit 3 of byte 2.
  - Required: tx=1 in the same cycle; state=IDLE; after release with the FIFO non-empty, the next pop begins a fresh word starting with a start bit.
- Parameter sweep:
  - Stimulus: CLKS_PER_BIT=2 and 16 with word 0xDEADBEEF.
  - Required: bytes 0xEF, 0xBE, 0xAD, 0xDE; frame lengths 20 and 160 cycles respectively.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// Read-side drain engine: pops 32-bit words from a synchronous FIFO and
// serialises each one as four 8N1 UART frames, least-significant byte first.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              word_done
);

  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, STOP} state_t;

  state_t            state;
  state_t            next_state;
  logic [BW-1:0]     baud_cnt;
  logic [2:0]        bit_cnt;
  logic [1:0]        byte_idx;
  logic [DATA_W-1:0] word_reg;
  logic [7:0]        shifter;
  logic [7:0]        cur_byte;
  logic              baud_end;
  logic              tx_next;
  logic              rd_en_next;
  logic              done_next;

  assign baud_end = (baud_cnt == BW'(CLKS_PER_BIT - 1));
  assign cur_byte = word_reg[8*byte_idx +: 8];
  assign busy     = (state != IDLE);

  // Outputs are registered from the next-state decode so tx lines up with state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      byte_idx   <= '0;
      word_reg   <= '0;
      shifter    <= '0;
      tx         <= 1'b1;
      fifo_rd_en <= 1'b0;
      word_done  <= 1'b0;
    end else begin
      state      <= next_state;
      tx         <= tx_next;
      fifo_rd_en <= rd_en_next;
      word_done  <= done_next;

      if (next_state != state || !(state inside {START, DATA, STOP}) || baud_end)
        baud_cnt <= '0;
      else
        baud_cnt <= baud_cnt + BW'(1);

      if (state == LOAD) begin
        word_reg <= fifo_data;
        byte_idx <= '0;
      end
      if (state == START && baud_end) begin
        shifter <= cur_byte;
        bit_cnt <= '0;
      end
      if (state == DATA && baud_end) begin
        shifter <= {1'b0, shifter[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (state == STOP && baud_end && byte_idx != 2'd3)
        byte_idx <= byte_idx + 2'd1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (en && !fifo_empty) next_state = POP;
      POP:     next_state = LOAD;
      LOAD:    next_state = START;
      START:   if (baud_end) next_state = DATA;
      DATA:    if (baud_end && bit_cnt == 3'd7) next_state = STOP;
      STOP:    if (baud_end) next_state = (byte_idx == 2'd3) ? IDLE : START;
      default: next_state = IDLE;
    endcase
  end

  // During DATA the bit about to be driven is shifter[1] when the period ends.
  always_comb begin
    tx_next    = 1'b1;
    rd_en_next = (next_state == POP);
    done_next  = (state == STOP) && baud_end && (byte_idx == 2'd3);
    case (next_state)
      START: tx_next = 1'b0;
      DATA: begin
        if (state == START) tx_next = cur_byte[0];
        else if (baud_end)  tx_next = shifter[1];
        else                tx_next = shifter[0];
      end
      default: tx_next = 1'b1;
    endcase
  end

endmodule
